// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, read-owner codes
// and default bus widths.
package mem_arbiter_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        ARB_RUN    = 2'b00,
        ARB_DRAIN  = 2'b01,
        ARB_LOCKED = 2'b10
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_HOST = 2'b10
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU, host and memory bus signals of the arbiter. Handshake: a request is
// held until the cycle it is granted (cpu_stall low / host_gnt high); read data
// returns with rvalid exactly one cycle after that grant; writes complete on grant.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_halted;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_lock;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        input  mem_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata, cpu_halted,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        output mem_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata, cpu_halted,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_wait_ctr.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Used for the host wait count and the CPU stall count.
module arb_wait_ctr #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// CPU/host memory arbiter: CPU priority with bounded host wait, host lock mode.
// Define ARB_STALL_CNT_EN to build the CPU stall cycle counter on stall_cnt.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic [15:0]   stall_cnt,
    output arb_state_e    dbg_state,
    output logic [3:0]    dbg_wait_cnt
);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    arb_state_e    state_q, state_d;
    owner_e        rd_owner_q, rd_owner_d;
    logic [DW-1:0] cpu_rdata_q, host_rdata_q;
    logic [3:0]    wait_cnt;
    logic          cpu_gnt, host_gnt, force_host;
    logic          wait_clr, wait_en;

    always_comb begin
        state_d    = state_q;
        cpu_gnt    = 1'b0;
        host_gnt   = 1'b0;
        force_host = bus.host_req && (wait_cnt == WAIT_MAX);
        unique case (state_q)
            ARB_RUN: begin
                cpu_gnt  = bus.cpu_req && !force_host;
                host_gnt = force_host || (bus.host_req && !bus.cpu_req);
                if (bus.host_lock) state_d = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                host_gnt = bus.host_req;
                state_d  = bus.host_lock ? ARB_LOCKED : ARB_RUN;
            end
            ARB_LOCKED: begin
                host_gnt = bus.host_req;
                if (!bus.host_lock) state_d = ARB_RUN;
            end
            default: state_d = ARB_RUN;
        endcase
        if (rst) begin
            cpu_gnt  = 1'b0;
            host_gnt = 1'b0;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (cpu_gnt && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (host_gnt && !bus.host_we) begin
            rd_owner_d = OWN_HOST;
        end
    end

    // Returned data is captured so each requester's rdata holds between its reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_RUN;
            rd_owner_q   <= OWN_NONE;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            if (rd_owner_q == OWN_CPU)  cpu_rdata_q  <= bus.mem_rdata;
            if (rd_owner_q == OWN_HOST) host_rdata_q <= bus.mem_rdata;
        end
    end

    assign wait_clr = rst || host_gnt || !bus.host_req || (state_q == ARB_LOCKED);
    assign wait_en  = bus.host_req && !host_gnt;

    arb_wait_ctr #(.W(4), .MAX(WAIT_MAX)) u_wait_ctr (
        .clk   (clk),
        .clr_i (wait_clr),
        .en_i  (wait_en),
        .cnt_o (wait_cnt)
    );

    always_comb begin
        bus.mem_en    = cpu_gnt || host_gnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {AW{1'b0}};
        bus.mem_wdata = {DW{1'b0}};
        if (cpu_gnt) begin
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (host_gnt) begin
            bus.mem_we    = bus.host_we;
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
        end
    end

    // A read in flight when reset arrives never reports valid.
    assign bus.cpu_rvalid  = (rd_owner_q == OWN_CPU) && !rst;
    assign bus.host_rvalid = (rd_owner_q == OWN_HOST) && !rst;
    assign bus.cpu_rdata   = (rd_owner_q == OWN_CPU)  ? bus.mem_rdata : cpu_rdata_q;
    assign bus.host_rdata  = (rd_owner_q == OWN_HOST) ? bus.mem_rdata : host_rdata_q;
    assign bus.cpu_stall   = bus.cpu_req && !cpu_gnt;
    assign bus.cpu_halted  = (state_q == ARB_LOCKED) && !rst;
    assign bus.host_gnt    = host_gnt;

    assign dbg_state    = state_q;
    assign dbg_wait_cnt = wait_cnt;

`ifdef ARB_STALL_CNT_EN
    arb_wait_ctr #(.W(16), .MAX(16'hFFFF)) u_stall_ctr (
        .clk   (clk),
        .clr_i (rst),
        .en_i  (bus.cpu_stall),
        .cnt_o (stall_cnt)
    );
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory model, driver tasks, scoreboard
// queues for memory accesses and read returns, and a final report.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

`ifdef ARB_STALL_CNT_EN
    localparam int EXP_STALL = 10;
`else
    localparam int EXP_STALL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] stall_cnt;
    arb_state_e  dbg_state;
    logic [3:0]  dbg_wait_cnt;

    int checks = 0;
    int errors = 0;

    logic [13:0] mem_exp_q[$];
    logic [7:0]  cpu_exp_q[$];
    logic [7:0]  host_exp_q[$];
    logic [7:0]  mem[32];

    mem_arbiter_if bus_if ();

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .stall_cnt    (stall_cnt),
        .dbg_state    (dbg_state),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- synchronous memory model ----------------
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[3] = 8'hA5;
        mem[7] = 8'h5E;
        bus_if.mem_rdata = 8'h00;
    end

    always @(posedge clk) begin
        if (bus_if.mem_en) begin
            if (bus_if.mem_we) mem[bus_if.mem_addr] = bus_if.mem_wdata;
            else bus_if.mem_rdata <= mem[bus_if.mem_addr];
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic go(input logic cr, input logic cwe, input logic [4:0] ca, input logic [7:0] cd,
                      input logic hr, input logic hwe, input logic [4:0] ha, input logic [7:0] hd,
                      input logic lk);
        @(posedge clk);
        #1;
        bus_if.cpu_req    = cr;
        bus_if.cpu_we     = cwe;
        bus_if.cpu_addr   = ca;
        bus_if.cpu_wdata  = cd;
        bus_if.host_req   = hr;
        bus_if.host_we    = hwe;
        bus_if.host_addr  = ha;
        bus_if.host_wdata = hd;
        bus_if.host_lock  = lk;
    endtask

    task automatic go_idle(input logic lk);
        go(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, lk);
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic exp_mem(input logic we, input logic [4:0] a, input logic [7:0] d);
        mem_exp_q.push_back({we, a, d});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (bus_if.mem_en) begin
            if (mem_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected actual=%0h required=none at %0t",
                         {bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata}, $time);
            end else begin
                chk("mem_access", 32'({bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata}),
                    32'(mem_exp_q.pop_front()));
            end
        end
        if (bus_if.cpu_rvalid) begin
            if (cpu_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cpu_rvalid_unexpected actual=%0h required=none at %0t",
                         bus_if.cpu_rdata, $time);
            end else begin
                chk("cpu_rdata", 32'(bus_if.cpu_rdata), 32'(cpu_exp_q.pop_front()));
            end
        end
        if (bus_if.host_rvalid) begin
            if (host_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL host_rvalid_unexpected actual=%0h required=none at %0t",
                         bus_if.host_rdata, $time);
            end else begin
                chk("host_rdata", 32'(bus_if.host_rdata), 32'(host_exp_q.pop_front()));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus_if.cpu_req = 0; bus_if.cpu_we = 0; bus_if.cpu_addr = 0; bus_if.cpu_wdata = 0;
        bus_if.host_req = 0; bus_if.host_we = 0; bus_if.host_addr = 0; bus_if.host_wdata = 0;
        bus_if.host_lock = 0;
        repeat (2) @(posedge clk);

        // reset: requests present but nothing granted
        go(1'b1, 1'b0, 5'h03, 8'h00, 1'b1, 1'b0, 5'h1F, 8'h00, 1'b0);
        smp();
        chk("rst_mem_en", 32'(bus_if.mem_en), 0);
        chk("rst_host_gnt", 32'(bus_if.host_gnt), 0);
        chk("rst_cpu_rvalid", 32'(bus_if.cpu_rvalid), 0);
        chk("rst_host_rvalid", 32'(bus_if.host_rvalid), 0);
        chk("rst_halted", 32'(bus_if.cpu_halted), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_state", 32'(dbg_state), 32'(ARB_RUN));
        chk("rst_wait", 32'(dbg_wait_cnt), 0);
        go_idle(1'b0);
        rst = 1'b0;
        smp();

        // CPU read of 0x03 returns A5 one cycle later
        go(1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0);
        exp_mem(1'b0, 5'h03, 8'h00);
        cpu_exp_q.push_back(8'hA5);
        smp();
        chk("cpu_rd_stall", 32'(bus_if.cpu_stall), 0);
        go_idle(1'b0);
        smp();
        chk("cpu_rd_stall_n1", 32'(bus_if.cpu_stall), 0);

        // host write 3C to 0x1F, CPU idle
        go(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 5'h1F, 8'h3C, 1'b0);
        exp_mem(1'b1, 5'h1F, 8'h3C);
        smp();
        chk("hwr_gnt", 32'(bus_if.host_gnt), 1);
        go_idle(1'b0);
        smp();
        chk("hwr_no_rvalid", 32'({bus_if.host_rvalid, bus_if.cpu_rvalid}), 0);

        // continuous contention: host forced in every 5th cycle
        for (int k = 0; k < 10; k++) begin
            go(1'b1, 1'b0, 5'h03, 8'h00, 1'b1, 1'b0, 5'h1F, 8'h00, 1'b0);
            if (k == 4 || k == 9) begin
                exp_mem(1'b0, 5'h1F, 8'h00);
                host_exp_q.push_back(8'h3C);
            end else begin
                exp_mem(1'b0, 5'h03, 8'h00);
                cpu_exp_q.push_back(8'hA5);
            end
            smp();
            chk("cont_host_gnt", 32'(bus_if.host_gnt), (k == 4 || k == 9) ? 1 : 0);
            chk("cont_cpu_stall", 32'(bus_if.cpu_stall), (k == 4 || k == 9) ? 1 : 0);
        end

        // host drops its request while waiting: wait count clears, no grant
        for (int k = 0; k < 4; k++) begin
            go(1'b1, 1'b0, 5'h03, 8'h00, (k != 2 && k != 3), 1'b0, 5'h1F, 8'h00, 1'b0);
            exp_mem(1'b0, 5'h03, 8'h00);
            cpu_exp_q.push_back(8'hA5);
            smp();
            chk("drop_host_gnt", 32'(bus_if.host_gnt), 0);
            chk("drop_wait", 32'(dbg_wait_cnt), (k == 3) ? 0 : k);
        end

        // lock: CPU read completes in DRAIN, host owns memory while LOCKED
        go(1'b1, 1'b0, 5'h07, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
        exp_mem(1'b0, 5'h07, 8'h00);
        cpu_exp_q.push_back(8'h5E);
        smp();
        chk("lk_issue_stall", 32'(bus_if.cpu_stall), 0);
        chk("lk_issue_state", 32'(dbg_state), 32'(ARB_RUN));
        go(1'b1, 1'b0, 5'h07, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
        smp();
        chk("lk_drain_state", 32'(dbg_state), 32'(ARB_DRAIN));
        chk("lk_drain_stall", 32'(bus_if.cpu_stall), 1);
        chk("lk_drain_rvalid", 32'(bus_if.cpu_rvalid), 1);
        chk("lk_drain_halted", 32'(bus_if.cpu_halted), 0);
        for (int i = 0; i < 8; i++) begin
            go(1'b1, 1'b0, 5'h07, 8'h00, 1'b1, 1'b1, 5'(16 + i), 8'(8'hC0 + i), 1'b1);
            exp_mem(1'b1, 5'(16 + i), 8'(8'hC0 + i));
            smp();
            chk("lk_state", 32'(dbg_state), 32'(ARB_LOCKED));
            chk("lk_halted", 32'(bus_if.cpu_halted), 1);
            chk("lk_host_gnt", 32'(bus_if.host_gnt), 1);
            chk("lk_cpu_stall", 32'(bus_if.cpu_stall), 1);
        end
        go(1'b1, 1'b0, 5'h07, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0);
        smp();
        chk("unlk_still_locked", 32'(dbg_state), 32'(ARB_LOCKED));
        chk("unlk_stall", 32'(bus_if.cpu_stall), 1);
        go(1'b1, 1'b0, 5'h07, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0);
        exp_mem(1'b0, 5'h07, 8'h00);
        cpu_exp_q.push_back(8'h5E);
        smp();
        chk("unlk_state", 32'(dbg_state), 32'(ARB_RUN));
        chk("unlk_cpu_gnt", 32'(bus_if.cpu_stall), 0);
        chk("unlk_halted", 32'(bus_if.cpu_halted), 0);
        go(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 5'h12, 8'h00, 1'b0);
        exp_mem(1'b0, 5'h12, 8'h00);
        host_exp_q.push_back(8'hC2);
        smp();
        go_idle(1'b0);
        smp();

        // lock dropped during DRAIN: one DRAIN cycle, then RUN
        go_idle(1'b1);
        smp();
        go_idle(1'b0);
        smp();
        chk("tog_drain", 32'(dbg_state), 32'(ARB_DRAIN));
        go_idle(1'b0);
        smp();
        chk("tog_run", 32'(dbg_state), 32'(ARB_RUN));

        // reset the cycle after a host read issue discards its rvalid
        go(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 5'h03, 8'h00, 1'b0);
        exp_mem(1'b0, 5'h03, 8'h00);
        smp();
        chk("rmr_gnt", 32'(bus_if.host_gnt), 1);
        go_idle(1'b0);
        rst = 1'b1;
        smp();
        chk("rmr_rvalid_rst", 32'(bus_if.host_rvalid), 0);
        go_idle(1'b0);
        rst = 1'b0;
        smp();
        chk("rmr_rvalid", 32'(bus_if.host_rvalid), 0);
        chk("rmr_state", 32'(dbg_state), 32'(ARB_RUN));
        chk("rmr_wait", 32'(dbg_wait_cnt), 0);
        chk("rmr_stall_cnt", 32'(stall_cnt), 0);

        // ten stalled CPU cycles under lock
        go_idle(1'b1);
        smp();
        go_idle(1'b1);
        smp();
        for (int i = 0; i < 10; i++) begin
            go(1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
            smp();
            chk("sc_stall", 32'(bus_if.cpu_stall), 1);
        end
        go_idle(1'b0);
        smp();
        chk("sc_stall_cnt", 32'(stall_cnt), EXP_STALL);
        go_idle(1'b0);
        smp();
        go_idle(1'b0);
        smp();

        // report
        chk("mem_q_empty", 32'(mem_exp_q.size()), 0);
        chk("cpu_q_empty", 32'(cpu_exp_q.size()), 0);
        chk("host_q_empty", 32'(host_exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
